// File: rtl/video_pkg.sv
// Shared types for the video capture path: pixel and FIFO word formats,
// the pixel-domain capture states, the bus-side write states, and the
// default frame geometry.
package video_pkg;

    typedef logic [23:0] pixel_t;

    typedef struct packed {
        logic        sof;
        logic [31:0] data;
    } cap_word_t;

    typedef enum logic [1:0] {
        WAIT_VS,
        WAIT_VIS,
        CAPTURE
    } cap_state_t;

    typedef enum logic [0:0] {
        BUS_IDLE,
        BUS_WRITE
    } bus_state_t;

    localparam int unsigned DEF_HDISP = 800;
    localparam int unsigned DEF_VDISP = 480;
    localparam int unsigned FIFO_AW   = 4;

endpackage

// File: rtl/video_if.sv
// Parallel video link: HS/VS active low, BLANK high on active pixels.
interface video_if;
    import video_pkg::*;

    logic   hs;
    logic   vs;
    logic   blank;
    pixel_t rgb;

    modport master (output hs, vs, blank, rgb);
    modport slave  (input  hs, vs, blank, rgb);
endinterface

// File: rtl/wshb_if.sv
// Classic Wishbone bus with its own clock and async active-high reset.
interface wshb_if;
    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (input  clk, rst, dat_sm, ack, err, rty,
                    output adr, dat_ms, sel, cti, bte, cyc, stb, we);
    modport slave  (input  clk, rst, adr, dat_ms, sel, cti, bte, cyc, stb, we,
                    output dat_sm, ack, err, rty);
endinterface

// File: rtl/async_fifo.sv
// Dual-clock FIFO with Gray-coded pointers and two-flop synchronisers.
// Read data is show-ahead: rdata is the head word whenever rempty is low.
module async_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  rst,
    input  logic                  wclk,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    input  logic                  rclk,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wbin, wgray, wbin_next;
    logic [ADDR_WIDTH:0]   rbin, rgray, rbin_next;
    logic [ADDR_WIDTH:0]   rq1, rq2, wq1, wq2;

    assign wbin_next = wbin + 1'b1;
    assign rbin_next = rbin + 1'b1;
    assign wfull  = (wgray == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]});
    assign rempty = (rgray == wq2);
    assign rdata  = mem[rbin[ADDR_WIDTH-1:0]];

    // write pointer advances on every accepted write
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            wbin  <= '0;
            wgray <= '0;
        end else if (write && !wfull) begin
            wbin  <= wbin_next;
            wgray <= wbin_next ^ (wbin_next >> 1);
        end
    end

    // storage, no reset needed: pointers define validity
    always_ff @(posedge wclk) begin
        if (write && !wfull)
            mem[wbin[ADDR_WIDTH-1:0]] <= wdata;
    end

    // read pointer brought into the write domain
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rgray;
            rq2 <= rq1;
        end
    end

    // read pointer advances on every accepted pop
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rbin  <= '0;
            rgray <= '0;
        end else if (read && !rempty) begin
            rbin  <= rbin_next;
            rgray <= rbin_next ^ (rbin_next >> 1);
        end
    end

    // write pointer brought into the read domain
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= wgray;
            wq2 <= wq1;
        end
    end
endmodule

// File: rtl/vga_capture_sync.sv
// Pixel-domain capture: tracks VS/BLANK edges, counts x/y inside the frame
// and emits one FIFO word per active pixel. A write refused by a full FIFO
// sets the sticky overflow flag and abandons the frame.
// VGA_CAPTURE_PATTERN_EN: replace RGB with {x[7:0], y[7:0], 8'hA5}.
module vga_capture_sync
    import video_pkg::*;
#(
    parameter int unsigned HDISP = DEF_HDISP,
    parameter int unsigned VDISP = DEF_VDISP
) (
    input  logic      pixel_clk,
    input  logic      pixel_rst,
    input  logic      vs,
    input  logic      blank,
    input  pixel_t    rgb,
    input  logic      wfull,
    output logic      write,
    output cap_word_t wdata,
    output logic      overflow
);
    localparam int unsigned XW = $clog2(HDISP);
    localparam int unsigned YW = $clog2(VDISP);

    cap_state_t    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    // x alone cannot hold HDISP, so a flag marks a full line
    logic          x_done;
    logic          vs_q, blank_q;
    logic          vs_fall, blank_fall;
    logic [31:0]   cur_data;

    assign vs_fall    = vs_q & ~vs;
    assign blank_fall = blank_q & ~blank;

`ifdef VGA_CAPTURE_PATTERN_EN
    logic unused_rgb;
    assign unused_rgb = ^rgb;
    assign cur_data   = {8'(x), 8'(y), 8'hA5};
`else
    assign cur_data   = {8'h00, rgb};
`endif

    // capture FSM with registered FIFO write and data
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state    <= WAIT_VS;
            x        <= '0;
            y        <= '0;
            x_done   <= 1'b0;
            overflow <= 1'b0;
            write    <= 1'b0;
            wdata    <= '0;
            vs_q     <= 1'b1;
            blank_q  <= 1'b0;
        end else begin
            vs_q    <= vs;
            blank_q <= blank;
            write   <= 1'b0;
            if (write && wfull) begin
                overflow <= 1'b1;
                state    <= WAIT_VS;
                x        <= '0;
                y        <= '0;
                x_done   <= 1'b0;
            end else begin
                case (state)
                    WAIT_VS: begin
                        if (vs_fall)
                            state <= WAIT_VIS;
                    end
                    WAIT_VIS: begin
                        if (blank) begin
                            write  <= 1'b1;
                            wdata  <= '{sof: 1'b1, data: cur_data};
                            x      <= x + XW'(1);
                            x_done <= (x == XW'(HDISP - 1));
                            state  <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (vs_fall) begin
                            state  <= WAIT_VIS;
                            x      <= '0;
                            y      <= '0;
                            x_done <= 1'b0;
                        end else if (blank_fall) begin
                            x      <= '0;
                            x_done <= 1'b0;
                            if (y == YW'(VDISP - 1)) begin
                                y     <= '0;
                                state <= WAIT_VS;
                            end else begin
                                y <= y + YW'(1);
                            end
                        end else if (blank && !x_done) begin
                            write  <= 1'b1;
                            wdata  <= '{sof: 1'b0, data: cur_data};
                            x      <= x + XW'(1);
                            x_done <= (x == XW'(HDISP - 1));
                        end
                    end
                    default: state <= WAIT_VS;
                endcase
            end
        end
    end
endmodule

// File: rtl/vga_capture.sv
// Video capture to SDRAM framebuffer: pixel-domain capture, a dual-clock
// FIFO, and a Wishbone single-write master that places each pixel at
// FB_BASE + 4*(HDISP*y + x). Optional VGA_CAPTURE_PATTERN_EN selects a
// synthetic {x, y, A5} pixel pattern instead of the RGB input.
module vga_capture
    import video_pkg::*;
#(
    parameter int unsigned HDISP   = DEF_HDISP,
    parameter int unsigned VDISP   = DEF_VDISP,
    parameter logic [31:0] FB_BASE = 32'h0
) (
    input  logic   pixel_clk,
    input  logic   pixel_rst,
    video_if.slave video_ifs,
    wshb_if.master wshb_ifm,
    output logic   overflow
);
    localparam int unsigned NWORDS = HDISP * VDISP;
    localparam int unsigned WW     = $clog2(NWORDS);

    logic          fifo_rst;
    logic          fifo_write, fifo_wfull;
    cap_word_t     fifo_wdata;
    logic          fifo_read, fifo_rempty;
    cap_word_t     head;
    bus_state_t    bus_state;
    logic [WW-1:0] wcnt, wcnt_eff;
    logic          presenting;
    logic          unused_bits;

    assign fifo_rst    = pixel_rst | wshb_ifm.rst;
    assign unused_bits = ^{video_ifs.hs, wshb_ifm.dat_sm, wshb_ifm.err, wshb_ifm.rty};

    vga_capture_sync #(
        .HDISP (HDISP),
        .VDISP (VDISP)
    ) u_sync (
        .pixel_clk (pixel_clk),
        .pixel_rst (pixel_rst),
        .vs        (video_ifs.vs),
        .blank     (video_ifs.blank),
        .rgb       (video_ifs.rgb),
        .wfull     (fifo_wfull),
        .write     (fifo_write),
        .wdata     (fifo_wdata),
        .overflow  (overflow)
    );

    async_fifo #(
        .DATA_WIDTH (33),
        .ADDR_WIDTH (FIFO_AW)
    ) u_fifo (
        .rst    (fifo_rst),
        .wclk   (pixel_clk),
        .write  (fifo_write),
        .wdata  (fifo_wdata),
        .wfull  (fifo_wfull),
        .rclk   (wshb_ifm.clk),
        .read   (fifo_read),
        .rdata  (head),
        .rempty (fifo_rempty)
    );

    // The head word is driven straight from the show-ahead FIFO output, so
    // it stays stable until popped and the next word appears the cycle after
    // ack without a staging register. A start-of-frame word restarts the
    // address count before its address reaches the bus.
    assign wcnt_eff   = head.sof ? '0 : wcnt;
    assign presenting = !fifo_rempty && !wshb_ifm.rst;
    assign fifo_read  = presenting && wshb_ifm.ack;

    assign wshb_ifm.cyc    = presenting;
    assign wshb_ifm.stb    = presenting;
    assign wshb_ifm.we     = presenting;
    assign wshb_ifm.sel    = 4'hF;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;
    assign wshb_ifm.adr    = FB_BASE + (32'(wcnt_eff) << 2);
    assign wshb_ifm.dat_ms = head.data;

    // bus-side state and framebuffer word counter
    always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
        if (wshb_ifm.rst) begin
            bus_state <= BUS_IDLE;
            wcnt      <= '0;
        end else begin
            if (fifo_read)
                wcnt <= (wcnt_eff == WW'(NWORDS - 1)) ? '0 : wcnt_eff + WW'(1);
            case (bus_state)
                BUS_IDLE:  if (presenting) bus_state <= BUS_WRITE;
                BUS_WRITE: if (!presenting) bus_state <= BUS_IDLE;
                default:   bus_state <= BUS_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture with a 16x8 frame at FB_BASE 0x100 and a
// Wishbone slave that acks one cycle after strobe unless stalled.
module tb_vga_capture;
    localparam int          HD   = 16;
    localparam int          VD   = 8;
    localparam logic [31:0] BASE = 32'h100;

    logic pclk = 1'b0;
    logic wclk = 1'b0;
    logic prst;
    logic ovf;
    logic stall;

    int tests = 0;
    int fails = 0;
    int attr_err = 0;

    logic [31:0] mon_adr[$];
    logic [31:0] mon_dat[$];

    video_if vif ();
    wshb_if  wb ();

    always #5 pclk = ~pclk;
    always #2 wclk = ~wclk;

    assign wb.clk    = wclk;
    assign wb.dat_sm = '0;
    assign wb.err    = 1'b0;
    assign wb.rty    = 1'b0;

    vga_capture #(
        .HDISP   (HD),
        .VDISP   (VD),
        .FB_BASE (BASE)
    ) dut (
        .pixel_clk (pclk),
        .pixel_rst (prst),
        .video_ifs (vif),
        .wshb_ifm  (wb),
        .overflow  (ovf)
    );

    always @(posedge wclk or posedge wb.rst) begin
        if (wb.rst) wb.ack <= 1'b0;
        else        wb.ack <= wb.cyc & wb.stb & ~wb.ack & ~stall;
    end

    always @(negedge wclk) begin
        if (wb.cyc && wb.stb && wb.ack) begin
            mon_adr.push_back(wb.adr);
            mon_dat.push_back(wb.dat_ms);
            if (!wb.we || wb.sel !== 4'hF || wb.cti !== 3'b000) attr_err++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] pix(input int x, input int y);
        if (x < HD) return 24'(y * 16 + x);
        return 24'hF00000 | 24'(x);
    endfunction

    function automatic logic [31:0] exp_dat(input int x, input int y);
`ifdef VGA_CAPTURE_PATTERN_EN
        return {8'(x), 8'(y), 8'hA5};
`else
        return {8'h00, 24'(y * 16 + x)};
`endif
    endfunction

    task automatic drive_frame(input int active);
        @(negedge pclk);
        vif.vs = 1'b0; vif.blank = 1'b0; vif.rgb = 24'hDEAD00;
        repeat (2) @(negedge pclk);
        vif.vs = 1'b1;
        repeat (4) @(negedge pclk);
        for (int y = 0; y < VD; y++) begin
            for (int x = 0; x < active; x++) begin
                vif.blank = 1'b1; vif.rgb = pix(x, y); vif.hs = 1'b1;
                @(negedge pclk);
            end
            vif.blank = 1'b0; vif.rgb = 24'hDEAD00;
            for (int b = 0; b < 8; b++) begin
                vif.hs = (b >= 2 && b < 4) ? 1'b0 : 1'b1;
                @(negedge pclk);
            end
        end
        repeat (4) @(negedge pclk);
    endtask

    task automatic wait_writes(input int n);
        int k = 0;
        while (mon_adr.size() < n && k < 4000) begin
            @(negedge wclk);
            k++;
        end
        repeat (40) @(negedge wclk);
    endtask

    task automatic test_reset();
        prst = 1'b1; wb.rst = 1'b1; stall = 1'b0;
        vif.vs = 1'b1; vif.hs = 1'b1; vif.blank = 1'b0; vif.rgb = '0;
        repeat (3) @(negedge pclk);
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b required 0", ovf); end
        tests++; if (wb.cyc !== 1'b0) begin fails++; $display("FAIL reset_cyc: got %b required 0", wb.cyc); end
        tests++; if (wb.stb !== 1'b0) begin fails++; $display("FAIL reset_stb: got %b required 0", wb.stb); end
        prst = 1'b0; wb.rst = 1'b0;
        repeat (5) @(negedge pclk);
        tests++; if (wb.cyc !== 1'b0 || wb.we !== 1'b0) begin fails++; $display("FAIL idle_cyc_we: got %b%b required 00", wb.cyc, wb.we); end
    endtask

    task automatic test_ramp();
        int i;
        mon_adr.delete(); mon_dat.delete();
        drive_frame(HD);
        wait_writes(HD * VD);
        tests++; if (mon_adr.size() !== HD * VD) begin fails++; $display("FAIL ramp_count: got %0d required %0d", mon_adr.size(), HD * VD); end
        for (i = 0; i < HD * VD && i < mon_adr.size(); i++) begin
            tests++;
            if (mon_adr[i] !== BASE + 32'(4 * i) || mon_dat[i] !== exp_dat(i % HD, i / HD)) begin
                fails++;
                $display("FAIL ramp_word %0d: got adr %h dat %h required adr %h dat %h", i, mon_adr[i], mon_dat[i], BASE + 32'(4 * i), exp_dat(i % HD, i / HD));
            end
        end
        tests++; if (attr_err !== 0) begin fails++; $display("FAIL ramp_attr: got %0d bad we/sel/cti required 0", attr_err); end
        if (mon_adr.size() > 37) begin
            tests++;
            if (mon_adr[37] !== 32'h194 || mon_dat[37] !== exp_dat(5, 2)) begin
                fails++;
                $display("FAIL pixel_5_2: got adr %h dat %h required adr 00000194 dat %h", mon_adr[37], mon_dat[37], exp_dat(5, 2));
            end
        end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ramp_ovf: got %b required 0", ovf); end
    endtask

    task automatic test_stall();
        int i;
        mon_adr.delete(); mon_dat.delete();
        fork
            drive_frame(HD);
            begin
                int k = 0;
                logic got = 1'b0;
                logic stable = 1'b1;
                logic [31:0] a0, d0;
                repeat (80) @(negedge pclk);
                stall = 1'b1;
                while (!got && k < 50) begin
                    @(negedge wclk);
                    k++;
                    if (wb.cyc && wb.stb && !wb.ack) got = 1'b1;
                end
                tests++; if (got !== 1'b1) begin fails++; $display("FAIL stall_stb: got stb %b required 1", got); end
                a0 = wb.adr; d0 = wb.dat_ms;
                repeat (20) begin
                    @(negedge wclk);
                    if (!(wb.cyc && wb.stb) || wb.ack || wb.adr !== a0 || wb.dat_ms !== d0) stable = 1'b0;
                end
                tests++; if (stable !== 1'b1) begin fails++; $display("FAIL stall_hold: got stable %b required 1 (adr %h dat %h)", stable, a0, d0); end
                stall = 1'b0;
            end
        join
        wait_writes(HD * VD);
        tests++; if (mon_adr.size() !== HD * VD) begin fails++; $display("FAIL stall_count: got %0d required %0d", mon_adr.size(), HD * VD); end
        for (i = 0; i < HD * VD && i < mon_adr.size(); i++) begin
            tests++;
            if (mon_adr[i] !== BASE + 32'(4 * i) || mon_dat[i] !== exp_dat(i % HD, i / HD)) begin
                fails++;
                $display("FAIL stall_word %0d: got adr %h dat %h required adr %h dat %h", i, mon_adr[i], mon_dat[i], BASE + 32'(4 * i), exp_dat(i % HD, i / HD));
            end
        end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL stall_ovf: got %b required 0", ovf); end
    endtask

    task automatic test_long_line();
        int i;
        mon_adr.delete(); mon_dat.delete();
        drive_frame(20);
        wait_writes(HD * VD);
        tests++; if (mon_adr.size() !== HD * VD) begin fails++; $display("FAIL long_count: got %0d required %0d", mon_adr.size(), HD * VD); end
        if (mon_adr.size() > 16) begin
            tests++;
            if (mon_adr[16] !== BASE + 32'd64 || mon_dat[16] !== exp_dat(0, 1)) begin
                fails++;
                $display("FAIL long_line1_start: got adr %h dat %h required adr %h dat %h", mon_adr[16], mon_dat[16], BASE + 32'd64, exp_dat(0, 1));
            end
        end
        for (i = 0; i < HD * VD && i < mon_adr.size(); i++) begin
            tests++;
            if (mon_adr[i] !== BASE + 32'(4 * i) || mon_dat[i] !== exp_dat(i % HD, i / HD)) begin
                fails++;
                $display("FAIL long_word %0d: got adr %h dat %h required adr %h dat %h", i, mon_adr[i], mon_dat[i], BASE + 32'(4 * i), exp_dat(i % HD, i / HD));
            end
        end
    endtask

    task automatic test_overflow();
        stall = 1'b1;
        mon_adr.delete(); mon_dat.delete();
        drive_frame(HD);
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b required 1", ovf); end
        stall = 1'b0;
        wait_writes(16);
        tests++; if (mon_adr.size() !== 16) begin fails++; $display("FAIL ovf_fifo_words: got %0d required 16", mon_adr.size()); end
        if (mon_adr.size() > 0) begin
            tests++;
            if (mon_adr[0] !== BASE || mon_dat[0] !== exp_dat(0, 0)) begin
                fails++;
                $display("FAIL ovf_first_old: got adr %h dat %h required adr %h dat %h", mon_adr[0], mon_dat[0], BASE, exp_dat(0, 0));
            end
        end
        mon_adr.delete(); mon_dat.delete();
        drive_frame(HD);
        wait_writes(HD * VD);
        tests++; if (mon_adr.size() !== HD * VD) begin fails++; $display("FAIL ovf_next_count: got %0d required %0d", mon_adr.size(), HD * VD); end
        if (mon_adr.size() > 17) begin
            tests++;
            if (mon_adr[0] !== BASE || mon_dat[0] !== exp_dat(0, 0)) begin
                fails++;
                $display("FAIL ovf_next_first: got adr %h dat %h required adr %h dat %h", mon_adr[0], mon_dat[0], BASE, exp_dat(0, 0));
            end
            tests++;
            if (mon_adr[17] !== BASE + 32'd68 || mon_dat[17] !== exp_dat(1, 1)) begin
                fails++;
                $display("FAIL ovf_next_17: got adr %h dat %h required adr %h dat %h", mon_adr[17], mon_dat[17], BASE + 32'd68, exp_dat(1, 1));
            end
        end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b required 1", ovf); end
    endtask

    task automatic test_pixel_reset();
        int i;
        fork
            drive_frame(HD);
            begin
                repeat (6 + 3 * 24 + 8) @(negedge pclk);
                prst = 1'b1;
                mon_adr.delete(); mon_dat.delete();
                repeat (2) @(negedge pclk);
                prst = 1'b0;
            end
        join
        repeat (200) @(negedge wclk);
        tests++; if (mon_adr.size() !== 0) begin fails++; $display("FAIL rst_no_writes: got %0d required 0", mon_adr.size()); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL rst_ovf_clear: got %b required 0", ovf); end
        drive_frame(HD);
        wait_writes(HD * VD);
        tests++; if (mon_adr.size() !== HD * VD) begin fails++; $display("FAIL rst_next_count: got %0d required %0d", mon_adr.size(), HD * VD); end
        for (i = 0; i < HD * VD && i < mon_adr.size(); i++) begin
            tests++;
            if (mon_adr[i] !== BASE + 32'(4 * i) || mon_dat[i] !== exp_dat(i % HD, i / HD)) begin
                fails++;
                $display("FAIL rst_word %0d: got adr %h dat %h required adr %h dat %h", i, mon_adr[i], mon_dat[i], BASE + 32'(4 * i), exp_dat(i % HD, i / HD));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_stall();
        test_long_line();
        test_overflow();
        test_pixel_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
